// File: rtl/rs_pkg.sv
// Shared types and widths for the integer reservation station and its issue selector.
// The optional RS_AGE_ORDER_EN build also relies only on these definitions.
package rs_pkg;

    localparam int TAG_W    = 6;
    localparam int DATA_W   = 32;
    localparam int INST_W   = 10;
    localparam int RS2EXE_W = 80;
    localparam int CDB_W    = 38;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } rs_operand_t;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [TAG_W-1:0]  dest;
        rs_operand_t       op1;
        rs_operand_t       op2;
    } rs_entry_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [TAG_W-1:0]  dest;
        logic [DATA_W-1:0] opr1;
        logic [DATA_W-1:0] opr2;
    } rs2exe_t;

    // Build an operand at dispatch, taking the CDB value if it is broadcasting our source tag now.
    function automatic rs_operand_t capture_operand(input logic              rdy,
                                                    input logic [DATA_W-1:0] raw,
                                                    input logic [CDB_W-1:0]  cdb);
        rs_operand_t      op;
        logic [TAG_W-1:0] cdb_tag;
        cdb_tag  = cdb[CDB_W-1:DATA_W];
        op.rdy   = rdy;
        op.tag   = rdy ? '0 : raw[TAG_W-1:0];
        op.value = raw;
        if (!rdy && (cdb_tag != '0) && (raw[TAG_W-1:0] == cdb_tag)) begin
            op.rdy   = 1'b1;
            op.value = cdb[DATA_W-1:0];
        end
        return op;
    endfunction

    function automatic rs_operand_t snoop_operand(input rs_operand_t          op,
                                                  input logic [CDB_W-1:0]     cdb);
        rs_operand_t      res;
        logic [TAG_W-1:0] cdb_tag;
        cdb_tag = cdb[CDB_W-1:DATA_W];
        res     = op;
        if (!op.rdy && (cdb_tag != '0) && (op.tag == cdb_tag)) begin
            res.rdy   = 1'b1;
            res.value = cdb[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Issue picker: one-hot grant among ready entries, lowest index by default or oldest
// when RS_AGE_ORDER_EN is defined (age[i][j]=1 means entry i is older than entry j).
module rs_select
    import rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
`ifdef RS_AGE_ORDER_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
    input  logic [DEPTH-1:0]            cand,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);

    assign found = |cand;

`ifdef RS_AGE_ORDER_EN
    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_oldest
            logic [DEPTH-1:0] older;
            for (gj = 0; gj < DEPTH; gj++) begin : g_col
                assign older[gj] = age[gj][gi];
            end
            // A candidate wins only if no other candidate is older than it.
            assign grant[gi] = cand[gi] && !(|(cand & older));
        end
    endgenerate
`else
    assign grant = cand & (~cand + DEPTH'(1));
`endif

endmodule

// File: rtl/rs_integer.sv
// Integer reservation station: buffers dispatched ops, wakes operands from the CDB and
// issues one ready op per cycle to the ALU. Define RS_AGE_ORDER_EN for oldest-first issue.
module rs_integer
    import rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [INST_W-1:0]   disp_inst,
    input  logic [TAG_W-1:0]    disp_dest,
    input  logic                disp_op1_rdy,
    input  logic [DATA_W-1:0]   disp_op1,
    input  logic                disp_op2_rdy,
    input  logic [DATA_W-1:0]   disp_op2,
    input  logic [CDB_W-1:0]    cdb,
    output logic                exe_en,
    output logic [RS2EXE_W-1:0] rs2exe
);

    rs_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] free_mask;
    logic [DEPTH-1:0] alloc_onehot;
    logic [DEPTH-1:0] grant;
    logic             found;
    logic             accept;
    rs_entry_t        new_entry;
    rs2exe_t          issue_bundle;
    logic             exe_en_reg;
    rs2exe_t          rs2exe_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flags
            assign valid[gi] = entries[gi].valid;
            assign cand[gi]  = entries[gi].valid && entries[gi].op1.rdy && entries[gi].op2.rdy;
        end
    endgenerate

    // Free slots come from registered state only, so a slot issued this cycle is reused next cycle.
    assign free_mask    = ~valid;
    assign alloc_onehot = free_mask & (~free_mask + DEPTH'(1));
    assign disp_ready   = |free_mask;
    assign accept       = disp_valid && disp_ready && !flush;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.inst  = disp_inst;
        new_entry.dest  = disp_dest;
        new_entry.op1   = capture_operand(disp_op1_rdy, disp_op1, cdb);
        new_entry.op2   = capture_operand(disp_op2_rdy, disp_op2, cdb);
    end

`ifdef RS_AGE_ORDER_EN
    logic [DEPTH-1:0][DEPTH-1:0] age_reg;

    // A new entry is younger than every currently valid entry; its own row is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_reg <= '0;
        end else if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_onehot[j]) begin
                        age_reg[i][j] <= valid[i];
                    end
                    if (alloc_onehot[i]) begin
                        age_reg[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_select (
        .age   (age_reg),
        .cand  (cand),
        .grant (grant),
        .found (found)
    );
`else
    rs_select #(.DEPTH(DEPTH)) u_select (
        .cand  (cand),
        .grant (grant),
        .found (found)
    );
`endif

    always_comb begin
        issue_bundle = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_bundle.inst = entries[i].inst;
                issue_bundle.dest = entries[i].dest;
                issue_bundle.opr1 = entries[i].op1.value;
                issue_bundle.opr2 = entries[i].op2.value;
            end
        end
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            rs_entry_t entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (flush) begin
                    entry_reg.valid <= 1'b0;
                end else if (accept && alloc_onehot[gi]) begin
                    entry_reg <= new_entry;
                end else if (grant[gi]) begin
                    entry_reg.valid <= 1'b0;
                end else if (entry_reg.valid) begin
                    entry_reg.op1 <= snoop_operand(entry_reg.op1, cdb);
                    entry_reg.op2 <= snoop_operand(entry_reg.op2, cdb);
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_en_reg <= 1'b0;
            rs2exe_reg <= '0;
        end else if (flush) begin
            exe_en_reg <= 1'b0;
        end else begin
            exe_en_reg <= found;
            if (found) begin
                rs2exe_reg <= issue_bundle;
            end
        end
    end

    assign exe_en = exe_en_reg;
    assign rs2exe = rs2exe_reg;

endmodule

// File: tb/tb_rs_integer.sv
// Self-checking bench for rs_integer: directed scenarios plus randomized traffic checked
// against a sequence-numbered behavioural model of the reservation station.
module tb_rs_integer;
    import rs_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic                disp_valid = 1'b0;
    logic                disp_ready;
    logic [INST_W-1:0]   disp_inst = '0;
    logic [TAG_W-1:0]    disp_dest = '0;
    logic                disp_op1_rdy = 1'b0;
    logic [DATA_W-1:0]   disp_op1 = '0;
    logic                disp_op2_rdy = 1'b0;
    logic [DATA_W-1:0]   disp_op2 = '0;
    logic [CDB_W-1:0]    cdb = '0;
    logic                exe_en;
    logic [RS2EXE_W-1:0] rs2exe;

    int errors = 0;
    int checks = 0;

    rs_integer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_inst    (disp_inst),
        .disp_dest    (disp_dest),
        .disp_op1_rdy (disp_op1_rdy),
        .disp_op1     (disp_op1),
        .disp_op2_rdy (disp_op2_rdy),
        .disp_op2     (disp_op2),
        .cdb          (cdb),
        .exe_en       (exe_en),
        .rs2exe       (rs2exe)
    );

    always #5 clk = ~clk;

    // Reference model: entries with program-order sequence numbers.
    bit                m_valid [DEPTH];
    bit                m_r1    [DEPTH];
    bit                m_r2    [DEPTH];
    logic [TAG_W-1:0]  m_t1    [DEPTH];
    logic [TAG_W-1:0]  m_t2    [DEPTH];
    logic [DATA_W-1:0] m_v1    [DEPTH];
    logic [DATA_W-1:0] m_v2    [DEPTH];
    logic [INST_W-1:0] m_inst  [DEPTH];
    logic [TAG_W-1:0]  m_dest  [DEPTH];
    int                m_seq   [DEPTH];
    int                seq_ctr = 0;
    bit                exp_en = 1'b0;
    logic [79:0]       exp_bus = '0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        exp_en  = 1'b0;
        exp_bus = '0;
    endtask

    function automatic bit model_ready();
        bit r = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) r = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        int pick;
        int slot;
        logic [TAG_W-1:0]  ctag;
        logic [DATA_W-1:0] cval;
        ctag = cdb[CDB_W-1:DATA_W];
        cval = cdb[DATA_W-1:0];
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            exp_en = 1'b0;
            return;
        end
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_ORDER_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        slot = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && slot < 0) slot = i;
        if (pick >= 0) begin
            exp_en  = 1'b1;
            exp_bus = {m_inst[pick], m_dest[pick], m_v1[pick], m_v2[pick]};
        end else begin
            exp_en = 1'b0;
        end
        if (ctag != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && !m_r1[i] && m_t1[i] == ctag) begin m_r1[i] = 1'b1; m_v1[i] = cval; end
                if (m_valid[i] && !m_r2[i] && m_t2[i] == ctag) begin m_r2[i] = 1'b1; m_v2[i] = cval; end
            end
        end
        if (pick >= 0) m_valid[pick] = 1'b0;
        if (disp_valid && slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_inst[slot]  = disp_inst;
            m_dest[slot]  = disp_dest;
            m_seq[slot]   = seq_ctr;
            seq_ctr++;
            m_t1[slot] = disp_op1[TAG_W-1:0];
            m_t2[slot] = disp_op2[TAG_W-1:0];
            if (disp_op1_rdy) begin m_r1[slot] = 1'b1; m_v1[slot] = disp_op1; end
            else if (ctag != 0 && m_t1[slot] == ctag) begin m_r1[slot] = 1'b1; m_v1[slot] = cval; end
            else begin m_r1[slot] = 1'b0; m_v1[slot] = disp_op1; end
            if (disp_op2_rdy) begin m_r2[slot] = 1'b1; m_v2[slot] = disp_op2; end
            else if (ctag != 0 && m_t2[slot] == ctag) begin m_r2[slot] = 1'b1; m_v2[slot] = cval; end
            else begin m_r2[slot] = 1'b0; m_v2[slot] = disp_op2; end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic tick(input bit dv, input logic [9:0] inst, input logic [5:0] dest,
                        input bit r1, input logic [31:0] o1, input bit r2, input logic [31:0] o2,
                        input logic [5:0] ctag, input logic [31:0] cval, input bit fl);
        disp_valid   = dv;
        disp_inst    = inst;
        disp_dest    = dest;
        disp_op1_rdy = r1;
        disp_op1     = o1;
        disp_op2_rdy = r2;
        disp_op2     = o2;
        cdb          = {ctag, cval};
        flush        = fl;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] ctag, input logic [31:0] cval);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, ctag, cval, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (exe_en !== 1'b0 || rs2exe !== 80'd0 || disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial: exe_en=%b rs2exe=%h disp_ready=%b required 0/0/1", exe_en, rs2exe, disp_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tick(1'b1, 10'h3C5, 6'd9, 1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 6'd0, 32'd0, 1'b0);
        tick(1'b1, 10'h001, 6'd1, 1'b0, 32'd40, 1'b1, 32'd1, 6'd0, 32'd0, 1'b0);
        tick(1'b1, 10'h002, 6'd2, 1'b0, 32'd41, 1'b1, 32'd1, 6'd0, 32'd0, 1'b0);
        tick(1'b1, 10'h003, 6'd3, 1'b0, 32'd42, 1'b1, 32'd1, 6'd0, 32'd0, 1'b0);
        checks++;
        if (rs2exe !== exp_bus || rs2exe === 80'd0) begin
            errors++;
            $display("FAIL reset_preload: rs2exe=%h required %h", rs2exe, exp_bus);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (exe_en !== 1'b0 || rs2exe !== 80'd0 || disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: exe_en=%b rs2exe=%h disp_ready=%b required 0/0/1", exe_en, rs2exe, disp_ready);
        end
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        $display("reset: async reset with 3 entries valid checked");
    endtask

    task automatic test_basic_issue();
        tick(1'b1, 10'h000, 6'd5, 1'b1, 32'd3, 1'b1, 32'd4, 6'd0, 32'd0, 1'b0);
        checks++;
        if (exe_en !== 1'b0) begin
            errors++;
            $display("FAIL add_first_edge: exe_en=%b required 0", exe_en);
        end
        idle(6'd5, 32'd7);
        checks++;
        if (exe_en !== 1'b1 || rs2exe !== {10'h000, 6'd5, 32'd3, 32'd4}) begin
            errors++;
            $display("FAIL add_issue: exe_en=%b rs2exe=%h required 1/%h", exe_en, rs2exe, {10'h000, 6'd5, 32'd3, 32'd4});
        end
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b0 || rs2exe !== {10'h000, 6'd5, 32'd3, 32'd4}) begin
            errors++;
            $display("FAIL add_hold: exe_en=%b rs2exe=%h required 0 and held value", exe_en, rs2exe);
        end
        $display("basic: ADD dest=5 3+4 issued at second edge, rs2exe=%h", rs2exe);
    endtask

    task automatic test_wakeup();
        tick(1'b1, 10'h100, 6'd6, 1'b0, 32'd9, 1'b1, 32'd1, 6'd0, 32'd0, 1'b0);
        idle(6'd0, 32'd0);
        idle(6'd0, 32'd0);
        idle(6'd9, 32'd20);
        checks++;
        if (exe_en !== 1'b0) begin
            errors++;
            $display("FAIL wake_same_cycle: exe_en=%b required 0", exe_en);
        end
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b1 || rs2exe !== {10'h100, 6'd6, 32'd20, 32'd1}) begin
            errors++;
            $display("FAIL wake_issue: exe_en=%b rs2exe=%h required 1/%h", exe_en, rs2exe, {10'h100, 6'd6, 32'd20, 32'd1});
        end
        tick(1'b1, 10'h100, 6'd7, 1'b0, 32'd9, 1'b1, 32'd1, 6'd9, 32'd20, 1'b0);
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b1 || rs2exe !== {10'h100, 6'd7, 32'd20, 32'd1}) begin
            errors++;
            $display("FAIL bypass_issue: exe_en=%b rs2exe=%h required 1/%h", exe_en, rs2exe, {10'h100, 6'd7, 32'd20, 32'd1});
        end
        $display("wakeup: SUB woken by tag 9 and bypassed dispatch both carried opr1=20");
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++)
            tick(1'b1, 10'(i + 16), 6'(i + 20), 1'b0, 32'(11 + i), 1'b1, 32'(i), 6'd0, 32'd0, 1'b0);
        checks++;
        if (disp_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: disp_ready=%b required 0", disp_ready);
        end
        tick(1'b1, 10'h3FF, 6'd63, 1'b0, 32'd15, 1'b1, 32'd0, 6'd0, 32'd0, 1'b0);
        idle(6'd11, 32'd100);
        checks++;
        if (disp_ready !== 1'b0 || exe_en !== 1'b0) begin
            errors++;
            $display("FAIL full_wake: disp_ready=%b exe_en=%b required 0/0", disp_ready, exe_en);
        end
        idle(6'd0, 32'd0);
        checks++;
        if (disp_ready !== 1'b1 || exe_en !== 1'b1 || rs2exe !== {10'd16, 6'd20, 32'd100, 32'd0}) begin
            errors++;
            $display("FAIL full_free: disp_ready=%b exe_en=%b rs2exe=%h required 1/1/%h", disp_ready, exe_en, rs2exe, {10'd16, 6'd20, 32'd100, 32'd0});
        end
        idle(6'd15, 32'd5);
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b0) begin
            errors++;
            $display("FAIL full_dropped: exe_en=%b rs2exe=%h required 0 (dropped op must not exist)", exe_en, rs2exe);
        end
        tick(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 6'd0, 32'd0, 1'b1);
        $display("full: disp_ready low at %0d entries, fifth dispatch dropped", DEPTH);
    endtask

    task automatic test_age();
        logic [9:0] first_inst;
        logic [9:0] second_inst;
`ifdef RS_AGE_ORDER_EN
        first_inst  = 10'h0A1;
        second_inst = 10'h0B2;
`else
        first_inst  = 10'h0B2;
        second_inst = 10'h0A1;
`endif
        tick(1'b1, 10'h055, 6'd1, 1'b1, 32'd1, 1'b1, 32'd2, 6'd0, 32'd0, 1'b0);
        tick(1'b1, 10'h0A1, 6'd10, 1'b0, 32'd7, 1'b1, 32'd3, 6'd0, 32'd0, 1'b0);
        tick(1'b1, 10'h0B2, 6'd11, 1'b0, 32'd7, 1'b1, 32'd4, 6'd0, 32'd0, 1'b0);
        idle(6'd7, 32'd55);
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b1 || rs2exe[79:70] !== first_inst || rs2exe !== exp_bus) begin
            errors++;
            $display("FAIL age_first: exe_en=%b inst=%h rs2exe=%h required inst %h", exe_en, rs2exe[79:70], rs2exe, first_inst);
        end
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b1 || rs2exe[79:70] !== second_inst || rs2exe !== exp_bus) begin
            errors++;
            $display("FAIL age_second: exe_en=%b inst=%h rs2exe=%h required inst %h", exe_en, rs2exe[79:70], rs2exe, second_inst);
        end
        $display("age: issue order %h then %h", first_inst, second_inst);
    endtask

    task automatic test_flush();
        tick(1'b1, 10'h0C1, 6'd12, 1'b0, 32'd20, 1'b1, 32'd1, 6'd0, 32'd0, 1'b0);
        tick(1'b1, 10'h0C2, 6'd13, 1'b0, 32'd20, 1'b1, 32'd2, 6'd0, 32'd0, 1'b0);
        idle(6'd20, 32'd77);
        tick(1'b1, 10'h0C3, 6'd14, 1'b1, 32'd5, 1'b1, 32'd6, 6'd0, 32'd0, 1'b1);
        checks++;
        if (exe_en !== 1'b0 || disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_edge: exe_en=%b disp_ready=%b required 0/1", exe_en, disp_ready);
        end
        idle(6'd0, 32'd0);
        idle(6'd0, 32'd0);
        checks++;
        if (exe_en !== 1'b0 || disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_discard: exe_en=%b rs2exe=%h disp_ready=%b required 0/-/1", exe_en, rs2exe, disp_ready);
        end
        $display("flush: two ready entries and concurrent dispatch discarded");
    endtask

    task automatic test_random();
        int n_issue = 0;
        for (int c = 0; c < 300; c++) begin
            bit          dv, r1, r2, fl;
            logic [31:0] o1, o2;
            dv = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            r2 = ($urandom_range(0, 2) != 0);
            o1 = r1 ? $urandom() : (($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(1, 7)));
            o2 = r2 ? $urandom() : (($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(1, 7)));
            fl = ($urandom_range(0, 40) == 0);
            tick(dv, 10'($urandom()), 6'($urandom()), r1, o1, r2, o2,
                 6'($urandom_range(0, 7)), $urandom(), fl);
            checks++;
            if (exe_en !== exp_en || rs2exe !== exp_bus || disp_ready !== model_ready()) begin
                errors++;
                $display("FAIL random_cycle%0d: exe_en=%b rs2exe=%h disp_ready=%b required %b/%h/%b",
                         c, exe_en, rs2exe, disp_ready, exp_en, exp_bus, model_ready());
            end
            if (exp_en) n_issue++;
        end
        $display("random: 300 cycles, %0d issues compared against model", n_issue);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_age();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
